uart_tx_arbiter: RTL

Shares one UART transmitter core among `NUM_REQ` on-chip requesters, using round-robin arbitration with optional multi-byte packet locking. It sits between the requesting blocks and the transmitter. It sequences one frame at a time: it issues a start pulse, waits for frame completion, then enforces an inter-frame gap measured in baud ticks. A lock timeout prevents a stalled packet owner from holding the line forever.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_picker.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
// Holds the arbiter state encoding, the default frame width and an index wrap helper.
package uart_pkg;

    localparam int unsigned UART_DATA_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } arb_state_t;

    // Wraps an index already known to be below 2*n back into 0..n-1.
    function automatic int unsigned rr_wrap(input int unsigned i, input int unsigned n);
        return (i >= n) ? i - n : i;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder: returns the first asserted request
// at or above ptr, wrapping around, for reuse by any round-robin arbiter.
module rr_picker
    import uart_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;

    // Rotating a doubled copy puts requester ptr at bit 0.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!valid && req_rot[j]) begin
                valid = 1'b1;
                idx   = IW'(rr_wrap(ptr + j, N));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with packet locking, an inter-frame baud-tick gap and a lock timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_LEN     = UART_DATA_LEN,
    parameter int unsigned GAP_TICKS    = 16,
    parameter int unsigned LOCK_TIMEOUT = 160
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_data,
    input  logic                        baud_tick,
    input  logic                        tx_done,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        tx_start,
    output logic [DATA_LEN-1:0]         tx_data,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        locked,
    output logic                        busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int unsigned TO_W  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

    arb_state_t state, state_nxt;

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    owner_inc;
    logic                pick_valid;
    logic                win_valid;
    logic                win_last;
    logic                last_q;
    logic [DATA_LEN-1:0] win_data;
    logic [GAP_W-1:0]    gap_cnt;
    logic [TO_W-1:0]     to_cnt;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_inc = (owner == IDX_MAX) ? '0 : owner + 1'b1;

    // A locked packet owner is the only eligible requester.
    assign win_valid = locked ? req[owner] : pick_valid;
    assign win_idx   = locked ? owner : pick_idx;

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = req_data[i*DATA_LEN +: DATA_LEN];
                win_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        tx_start  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                tx_start   = 1'b1;
                gnt[owner] = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    state_nxt = (GAP_TICKS > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (baud_tick && gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= '0;
            tx_data <= '0;
            last_q  <= 1'b0;
            locked  <= 1'b0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (state != IDLE) begin
                to_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        owner   <= win_idx;
                        tx_data <= win_data;
                        last_q  <= win_last;
                        to_cnt  <= '0;
                    end else if (locked && baud_tick) begin
                        // Owner's req is low here; a re-raised req takes the branch above.
                        if (to_cnt == TO_LAST) begin
                            locked <= 1'b0;
                            rr_ptr <= owner_inc;
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_q) begin
                        locked <= 1'b0;
                        rr_ptr <= owner_inc;
                    end else begin
                        locked <= 1'b1;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (baud_tick) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
